// File: rtl/spi_ram_master.sv
// spi_ram_master: host-side SPI sequencer for the SPI slave / RAM subsystem.
// Expands byte write/read requests into two-frame SPI command sequences.
module spi_ram_master #(
    parameter int CLK_DIV = 1,
    parameter int RD_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
    localparam logic [7:0] TURN_LAST = 8'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LEAD,
        S_SHIFT,
        S_TURN,
        S_CAP,
        S_GAP,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          ph_q, ph_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic          frame_q, frame_d;
    logic          op_q, op_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rdata_q, rdata_d;

    logic          timed;
    logic          run;
    logic          wrap;
    logic          pend;
    logic [1:0]    cmd;
    logic [7:0]    payload;
    logic [9:0]    word;
    logic [3:0]    sel;

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            ph_q    <= 1'b0;
            pcnt_q  <= '0;
            frame_q <= 1'b0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            ph_q    <= ph_d;
            pcnt_q  <= pcnt_d;
            frame_q <= frame_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: half-period timing, period counting and frame sequencing.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        hcnt_d  = '0;
        ph_d    = 1'b0;
        pcnt_d  = '0;

        timed = (state_q == S_LEAD) || (state_q == S_SHIFT) ||
                (state_q == S_TURN) || (state_q == S_CAP) ||
                (state_q == S_GAP);
        wrap  = (hcnt_q == HMAX);
        pend  = wrap & ph_q;

        if (timed) begin
            hcnt_d = wrap ? '0 : hcnt_q + 1'b1;
            ph_d   = ph_q ^ wrap;
            pcnt_d = pend ? pcnt_q + 8'd1 : pcnt_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_LOAD;
                    frame_d = 1'b0;
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            S_LOAD: begin
                state_d = S_LEAD;
            end
            S_LEAD: begin
                if (pend && pcnt_q == 8'd1) begin
                    state_d = S_SHIFT;
                    pcnt_d  = '0;
                end
            end
            S_SHIFT: begin
                if (pend && pcnt_q == 8'd9) begin
                    pcnt_d = '0;
                    if (op_q && frame_q) begin
                        state_d = (RD_WAIT == 0) ? S_CAP : S_TURN;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_TURN: begin
                if (pend && pcnt_q == TURN_LAST) begin
                    state_d = S_CAP;
                    pcnt_d  = '0;
                end
            end
            S_CAP: begin
                if (pend) begin
                    rx_d = {rx_q[6:0], MISO};
                end
                if (pend && pcnt_q == 8'd7) begin
                    state_d = S_GAP;
                    pcnt_d  = '0;
                end
            end
            S_GAP: begin
                if (pend && pcnt_q == 8'd1) begin
                    pcnt_d  = '0;
                    frame_d = 1'b1;
                    if (frame_q) begin
                        state_d = S_DONE;
                        if (op_q) begin
                            rdata_d = rx_q;
                        end
                    end else begin
                        state_d = S_LEAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin and handshake outputs decoded from the registered state.
    always_comb begin
        run = (state_q == S_LEAD) || (state_q == S_SHIFT) ||
              (state_q == S_TURN) || (state_q == S_CAP);
        cmd     = {op_q, frame_q};
        payload = frame_q ? (op_q ? 8'h00 : wdata_q) : addr_q;
        word    = {cmd, payload};
        sel     = 4'd9 - pcnt_q[3:0];

        MOSI = 1'b0;
        if (state_q == S_LEAD) begin
            MOSI = cmd[1];
        end else if (state_q == S_SHIFT) begin
            MOSI = word[sel];
        end

        SS_n      = ~run;
        SCLK      = ph_q & run;
        req_ready = (state_q == S_IDLE) & ~rst;
        rsp_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        rsp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: directed bench with a behavioural SPI RAM slave.
// Two instances: default timing and CLK_DIV=3 / RD_WAIT=1.
module tb_spi_ram_master;

    localparam int RW1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0;
    logic       req_op = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready, rsp_valid, busy, ss_n, sclk, mosi;
    logic [7:0] rsp_rdata;
    logic       miso = 1'b0;

    logic       req_valid2 = 1'b0;
    logic       req_op2 = 1'b0;
    logic [7:0] req_addr2 = 8'h00;
    logic [7:0] req_wdata2 = 8'h00;
    logic       req_ready2, rsp_valid2, busy2, ss_n2, sclk2, mosi2;
    logic [7:0] rsp_rdata2;
    logic       miso2 = 1'b1;

    spi_ram_master #(.CLK_DIV(1), .RD_WAIT(RW1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    spi_ram_master #(.CLK_DIV(3), .RD_WAIT(1)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_op(req_op2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .SS_n(ss_n2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural slave: frame log, RAM model, MISO drive, gap length.
    logic [7:0]  mem [256];
    logic        prev_sclk = 1'b0;
    logic        prev_ss = 1'b1;
    int          nrise = 0;
    logic [11:0] fbits = '0;
    logic [7:0]  s_addr = '0;
    logic [7:0]  s_rd = '0;
    logic [11:0] fq[$];
    int          nq[$];
    int          gap_run = 0;
    int          gap_min = 999;
    int          rsp_cnt = 0;

    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt++;
        if (!ss_n) begin
            if (prev_ss) begin
                if (fq.size() > 0 && gap_run < gap_min) gap_min = gap_run;
                nrise = 0;
                fbits = '0;
                miso = 1'b0;
            end
            if (sclk && !prev_sclk) begin
                nrise++;
                if (nrise <= 12) fbits = {fbits[10:0], mosi};
                if (nrise == 12 && fbits[9:8] == 2'b11) s_rd = mem[s_addr];
                if (nrise >= 13 + RW1 && nrise <= 20 + RW1)
                    miso = s_rd[20 + RW1 - nrise];
            end
        end else if (!prev_ss) begin
            fq.push_back(fbits);
            nq.push_back(nrise);
            if (nrise == 12) begin
                case (fbits[9:8])
                    2'b00, 2'b10: s_addr = fbits[7:0];
                    2'b01: mem[s_addr] = fbits[7:0];
                    default: ;
                endcase
            end
            miso = 1'b0;
            gap_run = 0;
        end
        if (ss_n) gap_run++;
        prev_ss = ss_n;
        prev_sclk = sclk;
    end

    // SCLK high/low run lengths of the divided instance while selected.
    int  run_len = 0;
    logic run_lvl = 1'b0;
    int  hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;

    task automatic rec_run(input logic lvl, input int len);
        if (lvl) begin
            if (len < hi_min) hi_min = len;
            if (len > hi_max) hi_max = len;
        end else begin
            if (len < lo_min) lo_min = len;
            if (len > lo_max) lo_max = len;
        end
    endtask

    always @(negedge clk) begin
        if (!ss_n2) begin
            if (run_len == 0 || sclk2 == run_lvl) begin
                run_len++;
            end else begin
                rec_run(run_lvl, run_len);
                run_len = 1;
            end
            run_lvl = sclk2;
        end else if (run_len > 0) begin
            rec_run(run_lvl, run_len);
            run_len = 0;
        end
    end

    function automatic logic [11:0] fr(input int i);
        return (i < fq.size()) ? fq[i] : 12'hFFF;
    endfunction

    function automatic int fn(input int i);
        return (i < nq.size()) ? nq[i] : -1;
    endfunction

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rsp_valid && n < 3000);
    endtask

    task automatic run_req(input logic op, input logic [7:0] a,
                           input logic [7:0] d, output int lat);
        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_addr = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(lat);
    endtask

    int lat;
    int rc0;
    int n2;

    initial begin
        mem[8'h3F] = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ss_n", ss_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", req_ready, 1);

        // Write A5 to 3F
        fq.delete(); nq.delete(); gap_min = 999;
        run_req(1'b0, 8'h3F, 8'hA5, lat);
        check("wr_lat", lat, 57);
        repeat (2) @(negedge clk);
        check("wr_nframes", fq.size(), 2);
        check("wr_f1", fr(0), 12'h03F);
        check("wr_f2", fr(1), 12'h1A5);
        check("wr_f1_len", fn(0), 12);
        check("wr_gap_ok", gap_min >= 4, 1);

        // Read 3F
        fq.delete(); nq.delete();
        run_req(1'b1, 8'h3F, 8'h00, lat);
        check("rd_lat", lat, 77);
        check("rd_data", rsp_rdata, 8'hA5);
        @(posedge clk);
        #1;
        check("rd_busy_after", busy, 0);
        check("rd_f1", fr(0), 12'hE3F);
        check("rd_f2", fr(1), 12'hF00);
        check("rd_f2_len", fn(1), 20 + RW1);

        // Back-to-back write then read, req_valid held
        fq.delete(); nq.delete();
        rc0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0;
        req_addr = 8'h10; req_wdata = 8'h5A;
        @(posedge clk);
        #1;
        req_op = 1'b1;
        wait_rsp(lat);
        check("b2b_wr_lat", lat, 57);
        check("b2b_ready_in_done", req_ready, 0);
        @(posedge clk);
        #1;
        check("b2b_ready_idle", req_ready, 1);
        @(posedge clk);
        #1;
        check("b2b_busy_acc", busy, 1);
        check("b2b_ready_acc", req_ready, 0);
        req_valid = 1'b0;
        wait_rsp(lat);
        check("b2b_rd_lat", lat, 77);
        check("b2b_rd_data", rsp_rdata, 8'h5A);
        repeat (4) @(negedge clk);
        check("b2b_rsp_cnt", rsp_cnt - rc0, 2);
        check("b2b_f3", fr(2), 12'hE10);

        // Request fields change while busy; latched values must be used
        fq.delete(); nq.delete();
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0;
        req_addr = 8'h22; req_wdata = 8'h3C;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            #1;
            req_addr = 8'(i * 7 + 1);
            req_wdata = 8'(~i);
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
        wait_rsp(lat);
        check("hold_lat", lat, 17);
        repeat (2) @(negedge clk);
        check("hold_f1", fr(0), 12'h022);
        check("hold_f2", fr(1), 12'h13C);

        // Reset during the 5th SHIFT bit of a write
        rc0 = rsp_cnt;
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0;
        req_addr = 8'h3F; req_wdata = 8'h00;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        check("abort_pre_ss", ss_n, 0);
        check("abort_pre_mosi", mosi, 1);
        rst = 1'b1;
        #1;
        check("abort_ss_n", ss_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_no_rsp", rsp_cnt - rc0, 0);
        run_req(1'b1, 8'h3F, 8'h00, lat);
        check("abort_rd_lat", lat, 77);
        check("abort_rd_data", rsp_rdata, 8'hA5);

        // Divided instance: CLK_DIV=3, RD_WAIT=1 read
        repeat (2) @(negedge clk);
        req_valid2 = 1'b1; req_op2 = 1'b1; req_addr2 = 8'h55;
        @(posedge clk);
        #1;
        req_valid2 = 1'b0;
        n2 = 0;
        do begin
            @(posedge clk);
            #1;
            n2++;
        end while (!rsp_valid2 && n2 < 3000);
        check("div3_lat", n2, 223);
        check("div3_rdata", rsp_rdata2, 8'hFF);
        repeat (2) @(negedge clk);
        check("div3_hi_min", hi_min, 3);
        check("div3_hi_max", hi_max, 3);
        check("div3_lo_min", lo_min, 3);
        check("div3_lo_max", lo_max, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
